// File: rtl/silo_rd_unpacker.sv
// Burst read unpacker: issues silo burst reads, remembers each burst's task template
// in order, and splits the returning beats into one tagged task per word.
package silo_rd_pkg;
  typedef struct packed {
    logic [31:0] ts;
    logic [7:0]  op;
  } task_t;

  typedef logic [2:0] subtype_t;
  typedef logic [3:0] cq_slice_slot_t;

  typedef struct packed {
    task_t          tsk;
    subtype_t       subtype;
    logic           mark_last;
    cq_slice_slot_t cq_slot;
    logic [7:0]     arlen;
  } meta_t;
endpackage

module silo_rd_unpacker
  import silo_rd_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TILE_ID = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_araddr,
  input  logic [7:0]               req_arlen,
  input  task_t                    req_task,
  input  subtype_t                 req_subtype,
  input  logic                     req_mark_last,
  input  cq_slice_slot_t           req_cq_slot,
  output logic                     mem_arvalid,
  input  logic                     mem_arready,
  output logic [31:0]              mem_araddr,
  output logic [7:0]               mem_arlen,
  output logic [2:0]               mem_arsize,
  input  logic                     mem_rvalid,
  output logic                     mem_rready,
  input  logic [31:0]              mem_rdata,
  input  logic                     mem_rlast,
  output logic                     out_valid,
  input  logic                     out_ready,
  output task_t                    out_task,
  output logic [31:0]              out_data,
  output logic [7:0]               out_word_id,
  output subtype_t                 out_subtype,
  output cq_slice_slot_t           out_cq_slot,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);

  meta_t         fifo_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic [7:0]    wcnt_q, wcnt_d;
  logic          err_q, err_d;

  meta_t head;
  logic  full, empty, push, pop, beat_hs, beat_end;

  assign full  = (occ_q == (AW+1)'(DEPTH));
  assign empty = (occ_q == '0);
  assign head  = fifo_q[rptr_q];

  // Request path is combinational; rst gates the handshake so nothing is issued while held.
  assign mem_arvalid = req_valid & ~full & ~rst;
  assign req_ready   = req_valid & ~full & mem_arready & ~rst;
  assign mem_araddr  = req_araddr;
  assign mem_arlen   = req_arlen;
  assign mem_arsize  = 3'd2;
  assign push        = req_ready;

  assign out_valid   = mem_rvalid & ~empty;
  assign mem_rready  = out_ready & ~empty;
  assign out_task    = head.tsk;
  assign out_data    = mem_rdata;
  assign out_word_id = wcnt_q;
  assign out_subtype = head.subtype;
  assign out_cq_slot = head.cq_slot;
  assign beat_end    = (wcnt_q == head.arlen);
  assign out_last    = head.mark_last & beat_end;
  assign beat_hs     = mem_rvalid & mem_rready;
  assign pop         = beat_hs & beat_end;

  assign occupancy   = occ_q;
  assign err         = err_q;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    wcnt_d = wcnt_q;
    err_d  = err_q;

    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;

    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    // The beat counter follows the stored arlen; rlast is only cross-checked.
    if (beat_hs) wcnt_d = beat_end ? 8'd0 : wcnt_q + 8'd1;

    if ((mem_rvalid & empty) | (beat_hs & (mem_rlast != beat_end))) err_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
      wcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
      wcnt_q <= wcnt_d;
      err_q  <= err_d;
    end
  end

  // NOTE: metadata storage is not reset; the pointers and occupancy decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wptr_q] <= '{tsk:       req_task,
                          subtype:   req_subtype,
                          mark_last: req_mark_last,
                          cq_slot:   req_cq_slot,
                          arlen:     req_arlen};
    end
  end

  counter_in_range: assert property (@(posedge clk) disable iff (rst)
    !empty |-> (wcnt_q <= head.arlen))
    else $error("silo_rd_unpacker tile %0d: beat counter passed burst length", TILE_ID);

endmodule

// File: tb/tb_silo_rd_unpacker.sv
// Directed bench for silo_rd_unpacker: stimulus tasks push expected words into a
// scoreboard queue, a negedge monitor pops and compares every emitted word.
module tb_silo_rd_unpacker;
  import silo_rd_pkg::*;

  localparam int DEPTH   = 8;
  localparam int TILE_ID = 0;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   req_valid;
  logic                   req_ready;
  logic [31:0]            req_araddr;
  logic [7:0]             req_arlen;
  task_t                  req_task;
  subtype_t               req_subtype;
  logic                   req_mark_last;
  cq_slice_slot_t         req_cq_slot;
  logic                   mem_arvalid;
  logic                   mem_arready;
  logic [31:0]            mem_araddr;
  logic [7:0]             mem_arlen;
  logic [2:0]             mem_arsize;
  logic                   mem_rvalid;
  logic                   mem_rready;
  logic [31:0]            mem_rdata;
  logic                   mem_rlast;
  logic                   out_valid;
  logic                   out_ready;
  task_t                  out_task;
  logic [31:0]            out_data;
  logic [7:0]             out_word_id;
  subtype_t               out_subtype;
  cq_slice_slot_t         out_cq_slot;
  logic                   out_last;
  logic [$clog2(DEPTH):0] occupancy;
  logic                   err;

  silo_rd_unpacker #(.DEPTH(DEPTH), .TILE_ID(TILE_ID)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_araddr(req_araddr),
    .req_arlen(req_arlen), .req_task(req_task), .req_subtype(req_subtype),
    .req_mark_last(req_mark_last), .req_cq_slot(req_cq_slot),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
    .mem_arlen(mem_arlen), .mem_arsize(mem_arsize),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
    .mem_rlast(mem_rlast),
    .out_valid(out_valid), .out_ready(out_ready), .out_task(out_task),
    .out_data(out_data), .out_word_id(out_word_id), .out_subtype(out_subtype),
    .out_cq_slot(out_cq_slot), .out_last(out_last),
    .occupancy(occupancy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ts;
    logic [31:0] data;
    logic [7:0]  id;
    logic [2:0]  sub;
    logic [3:0]  cq;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [7:0] op_of(input logic [31:0] ts);
    return ts[7:0] ^ 8'h5A;
  endfunction

  // Scoreboard monitor: a word is emitted when out_valid and out_ready are both high.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      $display("[TB] cyc %0d tile %0d cq %0d ts %0h word %0d data %0h",
               cyc, TILE_ID, out_cq_slot, out_task.ts, out_word_id, out_data);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word: got id %0d data %0h, expected no word", out_word_id, out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("word_ts",   out_task.ts, e.ts);
        check("word_op",   out_task.op, op_of(e.ts));
        check("word_data", out_data,    e.data);
        check("word_id",   out_word_id, e.id);
        check("word_sub",  out_subtype, e.sub);
        check("word_cq",   out_cq_slot, e.cq);
        check("word_last", out_last,    e.last);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] ts,
                         input logic [2:0] sub, input logic ml, input logic [3:0] cq);
    req_valid     = 1'b1;
    req_araddr    = addr;
    req_arlen     = len;
    req_task      = '{ts: ts, op: op_of(ts)};
    req_subtype   = sub;
    req_mark_last = ml;
    req_cq_slot   = cq;
  endtask

  task automatic issue(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] ts,
                       input logic [2:0] sub, input logic ml, input logic [3:0] cq);
    set_req(addr, len, ts, sub, ml, cq);
    mem_arready = 1'b1;
    #1;
    check("req_ready",   req_ready,   1'b1);
    check("mem_arvalid", mem_arvalid, 1'b1);
    check("mem_araddr",  mem_araddr,  addr);
    check("mem_arlen",   mem_arlen,   len);
    check("mem_arsize",  mem_arsize,  3'd2);
    tick();
    req_valid = 1'b0;
  endtask

  // Present one beat; optionally hold out_ready low for 'stall' cycles first.
  task automatic beat(input logic [31:0] data, input logic [7:0] id, input logic [31:0] ts,
                      input logic [2:0] sub, input logic [3:0] cq, input logic last,
                      input logic rlast, input int stall);
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    mem_rlast  = rlast;
    exp_q.push_back('{ts: ts, data: data, id: id, sub: sub, cq: cq, last: last});
    if (stall > 0) begin
      out_ready = 1'b0;
      repeat (stall) begin
        #1;
        check("stall_rready", mem_rready,  1'b0);
        check("stall_data",   out_data,    data);
        check("stall_id",     out_word_id, id);
        tick();
      end
    end
    out_ready = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    mem_rlast  = 1'b0;
    mem_rdata  = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    mem_arready = 1'b1;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    mem_rlast = 1'b0;
    out_ready = 1'b1;
    set_req(32'h0, 8'd0, 32'h0, 3'd0, 1'b0, 4'd0);

    // Reset state with requests and out_ready asserted.
    #3;
    check("rst_occupancy", occupancy,  '0);
    check("rst_err",       err,        1'b0);
    check("rst_req_ready", req_ready,  1'b0);
    check("rst_rready",    mem_rready, 1'b0);
    #4 rst = 1'b0;
    req_valid = 1'b0;
    tick();

    // Single burst of four words, last marker on word 3.
    issue(32'h1000, 8'd3, 32'h100, 3'd1, 1'b1, 4'd1);
    check("single_occ1", occupancy, 1);
    beat(32'hA, 8'd0, 32'h100, 3'd1, 4'd1, 1'b0, 1'b0, 0);
    beat(32'hB, 8'd1, 32'h100, 3'd1, 4'd1, 1'b0, 1'b0, 0);
    beat(32'hC, 8'd2, 32'h100, 3'd1, 4'd1, 1'b0, 1'b0, 0);
    beat(32'hD, 8'd3, 32'h100, 3'd1, 4'd1, 1'b1, 1'b1, 0);
    check("single_occ0", occupancy, 0);
    check("single_err",  err, 1'b0);

    // Same burst with out_ready low for five cycles at beat 2.
    issue(32'h1000, 8'd3, 32'h100, 3'd1, 1'b1, 4'd1);
    beat(32'hA, 8'd0, 32'h100, 3'd1, 4'd1, 1'b0, 1'b0, 0);
    beat(32'hB, 8'd1, 32'h100, 3'd1, 4'd1, 1'b0, 1'b0, 0);
    beat(32'hC, 8'd2, 32'h100, 3'd1, 4'd1, 1'b0, 1'b0, 5);
    beat(32'hD, 8'd3, 32'h100, 3'd1, 4'd1, 1'b1, 1'b1, 0);
    check("bp_occ0", occupancy, 0);

    // Fill the FIFO with single-beat bursts.
    for (int i = 0; i < DEPTH; i++)
      issue(32'h2000 + 32'(i) * 4, 8'd0, 32'h200 + 32'(i), 3'd2, 1'b0, 4'(i));
    check("full_occ", occupancy, DEPTH);
    set_req(32'h3000, 8'd0, 32'h300, 3'd2, 1'b1, 4'd9);
    #1;
    check("full_req_ready", req_ready,   1'b0);
    check("full_arvalid",   mem_arvalid, 1'b0);
    tick();
    // Pop and attempted push in the same cycle while full: push refused.
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h50;
    mem_rlast  = 1'b1;
    exp_q.push_back('{ts: 32'h200, data: 32'h50, id: 8'd0, sub: 3'd2, cq: 4'd0, last: 1'b0});
    #1;
    check("full_pop_req_ready", req_ready, 1'b0);
    tick();
    mem_rvalid = 1'b0;
    mem_rlast  = 1'b0;
    #1;
    check("after_pop_occ",       occupancy, DEPTH - 1);
    check("after_pop_req_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    check("refill_occ", occupancy, DEPTH);
    for (int i = 1; i < DEPTH; i++)
      beat(32'h50 + 32'(i), 8'd0, 32'h200 + 32'(i), 3'd2, 4'(i), 1'b0, 1'b1, 0);
    beat(32'h99, 8'd0, 32'h300, 3'd2, 4'd9, 1'b1, 1'b1, 0);
    check("drain_occ", occupancy, 0);

    // Interleaved bursts A(arlen=1, cq=3) then B(arlen=0, cq=5).
    issue(32'h4000, 8'd1, 32'h410, 3'd5, 1'b0, 4'd3);
    issue(32'h5000, 8'd0, 32'h420, 3'd6, 1'b1, 4'd5);
    check("inter_occ2", occupancy, 2);
    beat(32'h61, 8'd0, 32'h410, 3'd5, 4'd3, 1'b0, 1'b0, 0);
    beat(32'h62, 8'd1, 32'h410, 3'd5, 4'd3, 1'b0, 1'b1, 0);
    beat(32'h63, 8'd0, 32'h420, 3'd6, 4'd5, 1'b1, 1'b1, 0);
    check("inter_err", err, 1'b0);

    // Beat with an empty FIFO is refused and flags err.
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hEE;
    #1;
    check("empty_rready", mem_rready, 1'b0);
    check("empty_valid",  out_valid,  1'b0);
    tick();
    mem_rvalid = 1'b0;
    check("empty_err", err, 1'b1);
    rst = 1'b1;
    #1;
    check("err_cleared", err, 1'b0);
    tick();
    rst = 1'b0;

    // rlast on the wrong beat flags err but counting follows arlen.
    issue(32'h6000, 8'd1, 32'h510, 3'd3, 1'b1, 4'd6);
    beat(32'h11, 8'd0, 32'h510, 3'd3, 4'd6, 1'b0, 1'b1, 0);
    beat(32'h22, 8'd1, 32'h510, 3'd3, 4'd6, 1'b1, 1'b0, 0);
    check("rlast_err", err, 1'b1);
    check("rlast_occ", occupancy, 0);

    // Asynchronous reset between edges after two of four beats.
    issue(32'h7000, 8'd3, 32'h520, 3'd4, 1'b0, 4'd7);
    beat(32'h31, 8'd0, 32'h520, 3'd4, 4'd7, 1'b0, 1'b0, 0);
    beat(32'h32, 8'd1, 32'h520, 3'd4, 4'd7, 1'b0, 1'b0, 0);
    set_req(32'h8000, 8'd0, 32'h600, 3'd1, 1'b1, 4'd2);
    #2 rst = 1'b1;
    #1;
    check("async_occ",       occupancy, 0);
    check("async_err",       err,       1'b0);
    check("async_req_ready", req_ready, 1'b0);
    #1 rst = 1'b0;
    req_valid = 1'b0;
    tick();
    issue(32'h8000, 8'd0, 32'h600, 3'd1, 1'b1, 4'd2);
    beat(32'h77, 8'd0, 32'h600, 3'd1, 4'd2, 1'b1, 1'b1, 0);
    check("post_rst_occ", occupancy, 0);
    check("post_rst_err", err, 1'b0);

    tick();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
